// File: rtl/connector_pkg.sv
// connector_pkg
//   Shared constants and width helpers for the write-enable merge connector.
//   ch_width(n)  : bits needed to name one of n channels (at least 1).
//   cnt_width(d) : bits needed to hold an occupancy of 0..d.
package connector_pkg;

  localparam int DEF_NUM_CH = 3;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 4;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int d);
    return $clog2(d) + 1;
  endfunction

endpackage

// File: rtl/connector_ch_fifo.sv
// connector_ch_fifo
//   Single-channel DEPTH-entry FIFO with occupancy count.
//   clk, resetn     : clock, synchronous active-low reset
//   push, push_data : write request and data
//   pop             : remove head entry (ignored when empty)
//   head            : current head entry
//   count           : occupancy 0..DEPTH
//   empty, full     : occupancy flags
//   drop            : push refused this cycle (full and not popped)
module connector_ch_fifo
  import connector_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        push,
  input  logic [DATA_W-1:0]           push_data,
  input  logic                        pop,
  output logic [DATA_W-1:0]           head,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        empty,
  output logic                        full,
  output logic                        drop
);

  localparam int CNT_W = cnt_width(DEPTH);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic              pop_ok;
  logic              push_ok;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign pop_ok  = pop && !empty;
  // A full FIFO still takes a write when its head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && !push_ok;
  assign head    = mem[rptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && push_ok) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/connector_wen_merge.sv
// connector_wen_merge
//   Merges NUM_CH write-enable channels into one valid/ready output stream.
//   Each channel buffers into its own FIFO; a round-robin arbiter feeds a
//   single output register.
//   clk, resetn         : clock, synchronous active-low reset
//   wen, data           : per-channel write enable and packed write data
//   freeze              : blocks loading a new output word
//   out_valid/out_ready : output handshake
//   out_data, out_ch    : output word and its source channel
//   ovf, ovf_clr        : sticky per-channel overflow flags and their clear
//   level               : packed per-channel FIFO occupancy
module connector_wen_merge
  import connector_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                                 clk,
  input  logic                                 resetn,
  input  logic [NUM_CH-1:0]                    wen,
  input  logic [NUM_CH*DATA_W-1:0]             data,
  input  logic                                 freeze,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [DATA_W-1:0]                    out_data,
  output logic [ch_width(NUM_CH)-1:0]          out_ch,
  output logic [NUM_CH-1:0]                    ovf,
  input  logic                                 ovf_clr,
  output logic [NUM_CH*cnt_width(DEPTH)-1:0]   level
);

  localparam int CH_W  = ch_width(NUM_CH);
  localparam int CNT_W = cnt_width(DEPTH);

  logic [DATA_W-1:0] head [NUM_CH];
  logic [NUM_CH-1:0] fifo_empty;
  logic [NUM_CH-1:0] fifo_full;
  logic [NUM_CH-1:0] drop;
  logic [NUM_CH-1:0] pop;

  logic [CH_W-1:0]   last_grant;
  logic [CH_W-1:0]   grant;
  logic [CH_W-1:0]   idx;
  logic [DATA_W-1:0] grant_data;
  logic              any;
  logic              load;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign pop[g] = load && (grant == CH_W'(g));

    connector_ch_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .resetn    (resetn),
      .push      (wen[g]),
      .push_data (data[g*DATA_W +: DATA_W]),
      .pop       (pop[g]),
      .head      (head[g]),
      .count     (level[g*CNT_W +: CNT_W]),
      .empty     (fifo_empty[g]),
      .full      (fifo_full[g]),
      .drop      (drop[g])
    );
  end

  // Search starts one past the last granted channel and wraps.
  always_comb begin
    any        = 1'b0;
    grant      = '0;
    grant_data = '0;
    idx        = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = CH_W'((int'(last_grant) + k) % NUM_CH);
      if (!any && !fifo_empty[idx]) begin
        any        = 1'b1;
        grant      = idx;
        grant_data = head[idx];
      end
    end
  end

  assign load = (!out_valid || out_ready) && !freeze && any;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_ch     <= '0;
      last_grant <= CH_W'(NUM_CH - 1);
    end else if (load) begin
      out_valid  <= 1'b1;
      out_data   <= grant_data;
      out_ch     <= grant;
      last_grant <= grant;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  // A fresh overflow outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!resetn) ovf <= '0;
    else         ovf <= (ovf & ~{NUM_CH{ovf_clr}}) | drop;
  end

endmodule

// File: tb/tb_connector_wen_merge.sv
module tb_connector_wen_merge;

  logic        clk;
  logic        resetn;
  logic [2:0]  wen;
  logic [23:0] data;
  logic        freeze;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic [2:0]  ovf;
  logic        ovf_clr;
  logic [8:0]  level;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] c;
  } sb_t;

  sb_t q[$];
  logic sb_en = 1'b0;

  typedef struct {
    logic       rst;
    logic [2:0] wen;
    logic [7:0] d0, d1, d2;
    logic       rdy, frz;
    logic       ev;
    logic [7:0] ed;
    logic [1:0] ec;
    logic [2:0] l0, l1, l2;
  } vec_t;

  vec_t tbl[18];

  connector_wen_merge #(.NUM_CH(3), .DATA_W(8), .DEPTH(4)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .wen       (wen),
    .data      (data),
    .freeze    (freeze),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic rst, logic [2:0] w, logic [7:0] d0, logic [7:0] d1,
                              logic [7:0] d2, logic rdy, logic frz, logic ev, logic [7:0] ed,
                              logic [1:0] ec, logic [2:0] l0, logic [2:0] l1, logic [2:0] l2);
    vec_t v;
    v.rst = rst; v.wen = w; v.d0 = d0; v.d1 = d1; v.d2 = d2; v.rdy = rdy; v.frz = frz;
    v.ev = ev; v.ed = ed; v.ec = ec; v.l0 = l0; v.l1 = l1; v.l2 = l2;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn    = 1'b0;
    wen       = '0;
    data      = '0;
    ovf_clr   = 1'b0;
    q.delete();
    tick();
    resetn = 1'b1;
  endtask

  task automatic drain(input string nm);
    for (int n = 0; n < 20; n++) begin
      if (q.size() == 0) break;
      tick();
    end
    chk({nm, " drained"}, q.size(), 0);
    tick();
    chk({nm, " idle valid"}, {31'd0, out_valid}, 0);
  endtask

  initial begin
    resetn    = 1'b0;
    wen       = '0;
    data      = '0;
    freeze    = 1'b0;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;

    // row: rst wen d0 d1 d2 rdy frz | ev ed ec l0 l1 l2
    tbl[0]  = mk(1, 3'b001, 8'h5A, 0, 0, 1, 0,  0, 0,     0, 1, 0, 0);
    tbl[1]  = mk(1, 3'b000, 0, 0, 0,     1, 0,  1, 8'h5A, 0, 0, 0, 0);
    tbl[2]  = mk(1, 3'b000, 0, 0, 0,     1, 0,  0, 0,     0, 0, 0, 0);
    tbl[3]  = mk(0, 3'b111, 8'h11, 8'h22, 8'h33, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(1, 3'b111, 8'h11, 8'h22, 8'h33, 1, 0, 0, 0, 0, 1, 1, 1);
    tbl[5]  = mk(1, 3'b000, 0, 0, 0,     1, 0,  1, 8'h11, 0, 0, 1, 1);
    tbl[6]  = mk(1, 3'b000, 0, 0, 0,     1, 0,  1, 8'h22, 1, 0, 0, 1);
    tbl[7]  = mk(1, 3'b000, 0, 0, 0,     1, 0,  1, 8'h33, 2, 0, 0, 0);
    tbl[8]  = mk(1, 3'b000, 0, 0, 0,     1, 0,  0, 0,     0, 0, 0, 0);
    tbl[9]  = mk(1, 3'b001, 8'hA1, 0, 0, 1, 0,  0, 0,     0, 1, 0, 0);
    tbl[10] = mk(1, 3'b001, 8'hA2, 0, 0, 1, 0,  1, 8'hA1, 0, 1, 0, 0);
    tbl[11] = mk(1, 3'b001, 8'hA3, 0, 0, 1, 0,  1, 8'hA2, 0, 1, 0, 0);
    tbl[12] = mk(1, 3'b000, 0, 0, 0,     1, 0,  1, 8'hA3, 0, 0, 0, 0);
    tbl[13] = mk(1, 3'b000, 0, 0, 0,     1, 0,  0, 0,     0, 0, 0, 0);
    tbl[14] = mk(1, 3'b011, 8'hB0, 8'hB1, 0, 1, 0, 0, 0,  0, 1, 1, 0);
    tbl[15] = mk(1, 3'b000, 0, 0, 0,     1, 0,  1, 8'hB1, 1, 1, 0, 0);
    tbl[16] = mk(1, 3'b000, 0, 0, 0,     1, 0,  1, 8'hB0, 0, 0, 0, 0);
    tbl[17] = mk(1, 3'b000, 0, 0, 0,     1, 0,  0, 0,     0, 0, 0, 0);

    fork
      forever begin
        @(negedge clk);
        if (sb_en && resetn && out_valid && out_ready) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got data=%0h ch=%0d expected no word", out_data, out_ch);
          end else begin
            sb_t e;
            e = q.pop_front();
            if (out_data !== e.d || out_ch !== e.c) begin
              errors++;
              $display("FAIL sb_word: got data=%0h ch=%0d expected data=%0h ch=%0d",
                       out_data, out_ch, e.d, e.c);
            end
          end
        end
      end
    join_none

    tick();
    do_reset();
    chk("reset valid", {31'd0, out_valid}, 0);
    chk("reset data", {24'd0, out_data}, 0);
    chk("reset ch", {30'd0, out_ch}, 0);
    chk("reset ovf", {29'd0, ovf}, 0);
    chk("reset level", {23'd0, level}, 0);

    for (int i = 0; i < 18; i++) begin
      resetn    = tbl[i].rst;
      wen       = tbl[i].wen;
      data      = {tbl[i].d2, tbl[i].d1, tbl[i].d0};
      out_ready = tbl[i].rdy;
      freeze    = tbl[i].frz;
      tick();
      chk($sformatf("row%0d valid", i), {31'd0, out_valid}, {31'd0, tbl[i].ev});
      if (tbl[i].ev) begin
        chk($sformatf("row%0d data", i), {24'd0, out_data}, {24'd0, tbl[i].ed});
        chk($sformatf("row%0d ch", i), {30'd0, out_ch}, {30'd0, tbl[i].ec});
      end
      chk($sformatf("row%0d level", i), {23'd0, level}, {23'd0, tbl[i].l2, tbl[i].l1, tbl[i].l0});
      chk($sformatf("row%0d ovf", i), {29'd0, ovf}, 0);
    end
    wen = '0;

    // Overflow on ch1 while frozen, sticky flag, clear priority.
    do_reset();
    sb_en     = 1'b1;
    out_ready = 1'b0;
    freeze    = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wen  = 3'b010;
      data = {8'h00, 8'(8'h61 + k), 8'h00};
      if (k < 4) q.push_back({8'(8'h61 + k), 2'd1});
      tick();
    end
    wen = '0;
    chk("ovfA level", {23'd0, level}, {23'd0, 3'd0, 3'd4, 3'd0});
    chk("ovfA ovf", {29'd0, ovf}, 32'b010);
    chk("ovfA frozen valid", {31'd0, out_valid}, 0);
    tick();
    chk("ovfA sticky", {29'd0, ovf}, 32'b010);
    ovf_clr = 1'b1;
    wen     = 3'b010;
    data    = {8'h00, 8'h66, 8'h00};
    tick();
    chk("ovfA set wins", {29'd0, ovf}, 32'b010);
    wen = '0;
    tick();
    chk("ovfA cleared", {29'd0, ovf}, 0);
    ovf_clr   = 1'b0;
    freeze    = 1'b0;
    out_ready = 1'b1;
    drain("ovfA");

    // Stall hold, then freeze lets the presented word finish but blocks reload.
    do_reset();
    out_ready = 1'b0;
    freeze    = 1'b0;
    wen       = 3'b101;
    data      = {8'h72, 8'h00, 8'h70};
    q.push_back({8'h70, 2'd0});
    q.push_back({8'h72, 2'd2});
    tick();
    wen = '0;
    tick();
    chk("frzB first valid", {31'd0, out_valid}, 1);
    chk("frzB first data", {24'd0, out_data}, 32'h70);
    for (int k = 0; k < 3; k++) begin
      freeze = k[0];
      tick();
      chk($sformatf("frzB hold%0d valid", k), {31'd0, out_valid}, 1);
      chk($sformatf("frzB hold%0d data", k), {22'd0, out_ch, out_data}, {22'd0, 2'd0, 8'h70});
    end
    freeze    = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("frzB completed", {31'd0, out_valid}, 0);
    chk("frzB level2", {29'd0, level[8:6]}, 1);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk($sformatf("frzB blocked%0d", k), {31'd0, out_valid}, 0);
    end
    freeze = 1'b0;
    tick();
    chk("frzB reload valid", {31'd0, out_valid}, 1);
    chk("frzB reload word", {22'd0, out_ch, out_data}, {22'd0, 2'd2, 8'h72});
    drain("frzB");

    // Reset in the middle of operation discards everything.
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wen  = 3'b001;
      data = {16'h0000, 8'(8'h81 + k)};
      tick();
    end
    wen = '0;
    chk("rstC pre valid", {31'd0, out_valid}, 1);
    chk("rstC pre level0", {29'd0, level[2:0]}, 3);
    resetn = 1'b0;
    wen    = 3'b001;
    data   = {16'h0000, 8'h99};
    q.delete();
    tick();
    chk("rstC valid", {31'd0, out_valid}, 0);
    chk("rstC data", {24'd0, out_data}, 0);
    chk("rstC ch", {30'd0, out_ch}, 0);
    chk("rstC level", {23'd0, level}, 0);
    chk("rstC ovf", {29'd0, ovf}, 0);
    resetn    = 1'b1;
    wen       = 3'b101;
    data      = {8'hC2, 8'h00, 8'hC0};
    out_ready = 1'b1;
    q.push_back({8'hC0, 2'd0});
    q.push_back({8'hC2, 2'd2});
    tick();
    wen = '0;
    drain("rstC");

    sb_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
